bullet_pool_gen: RTL

BULLET_POOL_GEN -- requirements
Module: bullet_pool_gen

---
 rtl/bullet_pool_gen.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/bullet_pool_gen.sv
// rtl/bullet_pool_gen.sv - pooled bullet spawner/mover with LFSR lane select
module bullet_pool_gen #(
  parameter int          NUM_BULLETS  = 4,
  parameter int          SCREEN_WIDTH = 160,
  parameter int          SPAWN_PERIOD = 25_000_000,
  parameter int          MOVE_PERIOD  = 5_000_000,
  parameter int          STEP         = 1,
  parameter int          LANE_Y0      = 61,
  parameter int          LANE_Y1      = 71,
  parameter int          LANE_Y2      = 81,
  parameter int          LANE_Y3      = 91,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                     CLOCK_50,
  input  logic                     resetn,
  input  logic                     enable,
  input  logic                     player_collision,
  input  logic                     dir,
  input  logic [NUM_BULLETS-1:0]   bullet_hit,
  output logic [8*NUM_BULLETS-1:0] bullet_x,
  output logic [7*NUM_BULLETS-1:0] bullet_y,
  output logic [NUM_BULLETS-1:0]   bullet_active,
  output logic [3*NUM_BULLETS-1:0] bullet_color,
  output logic [7:0]               drop_count
);
  localparam int              SW         = $clog2(SPAWN_PERIOD);
  localparam int              MW         = $clog2(MOVE_PERIOD);
  localparam logic [SW-1:0]   SPAWN_LAST = SW'(SPAWN_PERIOD - 1);
  localparam logic [MW-1:0]   MOVE_LAST  = MW'(MOVE_PERIOD - 1);
  localparam logic [8:0]      X_MAX9     = 9'(SCREEN_WIDTH - 1);
  localparam logic [7:0]      X_MAX      = 8'(SCREEN_WIDTH - 1);
  localparam logic [8:0]      STEP9      = 9'(STEP);
  localparam logic [7:0]      STEP8      = 8'(STEP);

  logic [15:0]            r_lfsr;
  logic [SW-1:0]          r_spawn_cnt;
  logic [MW-1:0]          r_move_cnt;
  logic [7:0]             r_x [NUM_BULLETS];
  logic [6:0]             r_y [NUM_BULLETS];
  logic [NUM_BULLETS-1:0] r_act;
  logic [NUM_BULLETS-1:0] r_dir;
  logic [3*NUM_BULLETS-1:0] r_color;
  logic [7:0]             r_drop;

  logic                   w_run;
  logic                   w_spawn_tick;
  logic                   w_move_tick;
  logic                   w_found;
  logic [6:0]             w_lane_y;
  logic [NUM_BULLETS-1:0] w_spawn_oh;
  logic [NUM_BULLETS-1:0] w_act_nxt;
  logic [NUM_BULLETS-1:0] w_dir_nxt;
  logic [7:0]             w_x_nxt [NUM_BULLETS];
  logic [6:0]             w_y_nxt [NUM_BULLETS];

  assign w_run        = enable && !player_collision;
  assign w_spawn_tick = w_run && (r_spawn_cnt == SPAWN_LAST);
  assign w_move_tick  = w_run && (r_move_cnt == MOVE_LAST);

  always_comb begin
    case (r_lfsr[1:0])
      2'd0:    w_lane_y = 7'(LANE_Y0);
      2'd1:    w_lane_y = 7'(LANE_Y1);
      2'd2:    w_lane_y = 7'(LANE_Y2);
      default: w_lane_y = 7'(LANE_Y3);
    endcase
  end

  // Slots being hit this cycle are excluded so a cleared slot is never refilled at once.
  always_comb begin
    w_spawn_oh = '0;
    w_found    = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!r_act[i] && !bullet_hit[i] && !w_found) begin
        w_spawn_oh[i] = 1'b1;
        w_found       = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_BULLETS; i++) begin
      w_act_nxt[i] = r_act[i];
      w_dir_nxt[i] = r_dir[i];
      w_x_nxt[i]   = r_x[i];
      w_y_nxt[i]   = r_y[i];
      if (player_collision) begin
        w_act_nxt[i] = 1'b0;
        w_x_nxt[i]   = 8'd0;
      end else if (enable) begin
        if (bullet_hit[i]) begin
          w_act_nxt[i] = 1'b0;
        end else if (w_spawn_tick && w_spawn_oh[i]) begin
          w_act_nxt[i] = 1'b1;
          w_dir_nxt[i] = dir;
          w_x_nxt[i]   = dir ? X_MAX : 8'd0;
          w_y_nxt[i]   = w_lane_y;
        end else if (w_move_tick && r_act[i]) begin
          if (!r_dir[i]) begin
            if ({1'b0, r_x[i]} + STEP9 > X_MAX9) w_act_nxt[i] = 1'b0;
            else                                  w_x_nxt[i]   = r_x[i] + STEP8;
          end else begin
            if (r_x[i] < STEP8) w_act_nxt[i] = 1'b0;
            else                w_x_nxt[i]   = r_x[i] - STEP8;
          end
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_lfsr      <= LFSR_SEED;
      r_spawn_cnt <= '0;
      r_move_cnt  <= '0;
      r_act       <= '0;
      r_dir       <= '0;
      r_color     <= '1;
      r_drop      <= 8'd0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        r_x[i] <= 8'd0;
        r_y[i] <= 7'(LANE_Y1);
      end
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      if (w_run) begin
        r_spawn_cnt <= w_spawn_tick ? '0 : r_spawn_cnt + SW'(1);
        r_move_cnt  <= w_move_tick ? '0 : r_move_cnt + MW'(1);
      end
      if (w_spawn_tick && !w_found && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      r_act <= w_act_nxt;
      r_dir <= w_dir_nxt;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        r_x[i]             <= w_x_nxt[i];
        r_y[i]             <= w_y_nxt[i];
        r_color[3*i +: 3]  <= w_act_nxt[i] ? 3'b001 : 3'b111;
      end
    end
  end

  always_comb begin
    bullet_x = '0;
    bullet_y = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      bullet_x[8*i +: 8] = r_x[i];
      bullet_y[7*i +: 7] = r_y[i];
    end
  end

  assign bullet_active = r_act;
  assign bullet_color  = r_color;
  assign drop_count    = r_drop;
endmodule
